dcache_core_responder: RTL and testbench

// Cache-side responder of the core/cache request bus: accepts word reads issued by the

---
 rtl/dcache_core_responder_pkg.sv | 36 +++
 rtl/dcache_line_store.sv | 54 +++++
 rtl/dcache_core_responder.sv | 157 +++++++++++++++
 tb/tb_dcache_core_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_core_responder_pkg.sv
// Shared encodings, responder state type and geometry helpers for the data-cache responder.
package dcache_core_responder_pkg;

    localparam int DEF_ADDR_W     = 64;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_TAG_W      = 10;
    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 8;

    // reqtag = {op, space, opcode[7:0]}
    localparam logic OP_READ      = 1'b0;
    localparam logic OP_WRITE     = 1'b1;
    localparam logic SPACE_MEMORY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_RESPOND
    } rsp_state_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Address bits above index, offset and the 3 byte-select bits.
    function automatic int line_tag_bits(input int addr_w, input int lines, input int line_words);
        return addr_w - 3 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Direct-mapped tag/valid/data arrays: combinational read at idx/off, beat write, line validate.
// Valid bits reset and flush-clear; tag and data arrays hold no reset.
module dcache_line_store
    import dcache_core_responder_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LTAG_W     = 52
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush_all,
    input  logic [idx_bits(LINES)-1:0]      idx,
    input  logic [off_bits(LINE_WORDS)-1:0] off,
    output logic                            rd_valid,
    output logic [LTAG_W-1:0]               rd_tag,
    output logic [DATA_W-1:0]               rd_data,
    input  logic                            wr_en,
    input  logic [off_bits(LINE_WORDS)-1:0] wr_off,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            val_en,
    input  logic [LTAG_W-1:0]               val_tag
);

    logic [LINES-1:0]  valid;
    logic [LTAG_W-1:0] tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];

    // Flush wins over a same-edge validate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (val_en) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[idx][wr_off] <= wr_data;
        end
        if (val_en) begin
            tag_mem[idx] <= val_tag;
        end
    end

    assign rd_valid = valid[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_data  = data_mem[idx][off];

endmodule

// File: rtl/dcache_core_responder.sv
// Single-outstanding word-read responder over a direct-mapped read-only cache; hit latency 2.
// Requests wait unacked outside IDLE; respcyc/resp hold until respack; fills line-wide from memory.
module dcache_core_responder
    import dcache_core_responder_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reqcyc,
    input  logic [ADDR_W-1:0] req,
    input  logic [TAG_W-1:0]  reqtag,
    output logic              reqack,
    output logic              respcyc,
    output logic [DATA_W-1:0] resp,
    input  logic              respack,
    input  logic              flush,
    output logic              unsupported_req,
    output logic              mem_reqcyc,
    output logic [ADDR_W-1:0] mem_req,
    input  logic              mem_reqack,
    input  logic              mem_respcyc,
    input  logic [DATA_W-1:0] mem_resp,
    output logic              mem_respack
);

    localparam int OFF_W  = off_bits(LINE_WORDS);
    localparam int IDX_W  = idx_bits(LINES);
    localparam int LTAG_W = line_tag_bits(ADDR_W, LINES, LINE_WORDS);
    localparam int LSB    = OFF_W + 3;

    rsp_state_t state, state_nxt;

    logic [ADDR_W-4:0] addr_q;
    logic              op_q;
    logic [OFF_W-1:0]  beat;
    logic              flush_pend;
    logic [DATA_W-1:0] resp_q;

    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [LTAG_W-1:0] ltag;
    logic              rd_valid;
    logic [LTAG_W-1:0] rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              non_read;
    logic              beat_take;
    logic              last_beat;
    logic              resp_done;
    logic              clear_all;
    logic              unused_ok;

    assign off  = addr_q[OFF_W-1:0];
    assign idx  = addr_q[OFF_W +: IDX_W];
    assign ltag = addr_q[ADDR_W-4 -: LTAG_W];

    assign hit       = rd_valid && (rd_tag == ltag);
    assign non_read  = (op_q != OP_READ);
    assign beat_take = (state == ST_FILL_WAIT) && mem_respcyc;
    assign last_beat = beat_take && (beat == OFF_W'(LINE_WORDS - 1));
    assign resp_done = (state == ST_RESPOND) && respack;

    // A flush seen in IDLE acts at once; otherwise it waits for the return to IDLE.
    assign clear_all = ((state == ST_IDLE) && flush) || (resp_done && (flush_pend || flush));

    assign unused_ok = ^{reqtag[TAG_W-2:0], req[2:0]};

    dcache_line_store #(
        .DATA_W     (DATA_W),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .LTAG_W     (LTAG_W)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_all (clear_all),
        .idx       (idx),
        .off       (off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (beat_take),
        .wr_off    (beat),
        .wr_data   (mem_resp),
        .val_en    (last_beat),
        .val_tag   (ltag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (reqcyc) state_nxt = ST_LOOKUP;
            ST_LOOKUP:    state_nxt = (non_read || hit) ? ST_RESPOND : ST_FILL_REQ;
            ST_FILL_REQ:  if (mem_reqack) state_nxt = ST_FILL_WAIT;
            ST_FILL_WAIT: if (last_beat) state_nxt = ST_RESPOND;
            ST_RESPOND:   if (respack) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        reqack          = (state == ST_LOOKUP);
        unsupported_req = (state == ST_LOOKUP) && non_read;
        respcyc         = (state == ST_RESPOND);
        resp            = resp_q;
        mem_reqcyc      = (state == ST_FILL_REQ);
        mem_req         = {addr_q[ADDR_W-4:OFF_W], {LSB{1'b0}}};
        mem_respack     = beat_take;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            op_q       <= 1'b0;
            beat       <= '0;
            flush_pend <= 1'b0;
            resp_q     <= '0;
        end else begin
            if ((state == ST_IDLE) && reqcyc) begin
                addr_q <= req[ADDR_W-1:3];
                op_q   <= reqtag[TAG_W-1];
            end
            if (state == ST_LOOKUP) begin
                if (non_read) begin
                    resp_q <= '0;
                end else if (hit) begin
                    resp_q <= rd_data;
                end
            end
            if (beat_take) begin
                beat <= last_beat ? '0 : beat + OFF_W'(1);
                if (beat == off) begin
                    resp_q <= mem_resp;
                end
            end
            if (clear_all) begin
                flush_pend <= 1'b0;
            end else if (flush && (state != ST_IDLE)) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_core_responder.sv
// Scoreboard bench for dcache_core_responder with an inline lower-memory model.
module tb_dcache_core_responder;
    import dcache_core_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reqcyc;
    logic [63:0] req;
    logic [9:0]  reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic        respack;
    logic        flush;
    logic        unsupported_req;
    logic        mem_reqcyc;
    logic [63:0] mem_req;
    logic        mem_reqack;
    logic        mem_respcyc;
    logic [63:0] mem_resp;
    logic        mem_respack;

    dcache_core_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .reqcyc          (reqcyc),
        .req             (req),
        .reqtag          (reqtag),
        .reqack          (reqack),
        .respcyc         (respcyc),
        .resp            (resp),
        .respack         (respack),
        .flush           (flush),
        .unsupported_req (unsupported_req),
        .mem_reqcyc      (mem_reqcyc),
        .mem_req         (mem_req),
        .mem_reqack      (mem_reqack),
        .mem_respcyc     (mem_respcyc),
        .mem_resp        (mem_resp),
        .mem_respack     (mem_respack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] resp;
        logic [63:0] line;
        bit          miss;
        bit          unsup;
    } exp_t;

    exp_t        sb_q[$];
    bit          mvalid [64];
    logic [51:0] mtag   [64];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          unsup_seen = 0;
    int          ack_seen   = 0;
    logic [9:0]  tag_rd;
    logic [9:0]  tag_wr;

    always @(negedge clk) begin
        if (unsupported_req) unsup_seen++;
        if (mem_respack) ack_seen++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return 64'hCAFE_0000_0000_0000 ^ a;
    endfunction

    task automatic model_clear;
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [9:0] tag, input int hold,
                           input int flush_beat, input bit flush_req, input int rst_beat,
                           input bit gaps);
        exp_t        e;
        exp_t        got;
        int          idx;
        logic [51:0] t;
        int          n;
        int          t0;
        int          u0;
        int          a0;
        int          fill_beat;
        bit          saw_req;
        bit          done;
        bit          drove;
        bit          stable;
        logic [63:0] mreq;
        logic [63:0] r0;

        if (flush_req) model_clear();
        idx     = int'(addr[11:6]);
        t       = addr[63:12];
        e.unsup = (tag[9] != OP_READ);
        e.miss  = !e.unsup && !(mvalid[idx] && mtag[idx] == t);
        e.resp  = e.unsup ? 64'h0 : mem_word({addr[63:3], 3'b000});
        e.line  = {addr[63:6], 6'b0};
        sb_q.push_back(e);

        u0 = unsup_seen;
        a0 = ack_seen;
        t0 = cyc;
        req    = addr;
        reqtag = tag;
        reqcyc = 1'b1;
        flush  = flush_req;
        n = 0;
        do begin
            tick;
            flush = 1'b0;
            n++;
        end while (!reqack && n < 20);
        check_eq("reqack_lat", 64'(n), 64'd1);
        reqcyc = 1'b0;

        fill_beat = -1;
        saw_req   = 1'b0;
        done      = 1'b0;
        mreq      = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            mem_reqack  = 1'b0;
            mem_respcyc = 1'b0;
            drove       = 1'b0;
            if (respcyc) begin
                got = sb_q.pop_front();
                check_eq("resp", resp, got.resp);
                check_eq("fill_seen", 64'(saw_req), 64'(got.miss));
                if (saw_req) check_eq("mem_req", mreq, got.line);
                check_eq("beats", 64'(ack_seen - a0), got.miss ? 64'd8 : 64'd0);
                check_eq("unsup_pulses", 64'(unsup_seen - u0), 64'(got.unsup));
                if (!got.miss) check_eq("hit_lat", 64'(cyc - t0), 64'd2);
                r0 = resp;
                stable = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    tick;
                    stable = stable && (respcyc === 1'b1) && (resp === r0);
                end
                check_eq("resp_held", 64'(stable), 64'd1);
                respack = 1'b1;
                tick;
                respack = 1'b0;
                check_eq("resp_drop", 64'(respcyc), 64'd0);
                if (got.miss) begin
                    mvalid[idx] = 1'b1;
                    mtag[idx]   = t;
                end
                if (flush_beat >= 0) model_clear();
                done = 1'b1;
            end else begin
                if (mem_reqcyc) begin
                    if (!saw_req) begin
                        saw_req = 1'b1;
                        mreq    = mem_req;
                    end
                    mem_reqack = 1'b1;
                    fill_beat  = 0;
                end else if (fill_beat >= 0 && fill_beat < 8 &&
                             !(gaps && $urandom_range(0, 2) == 0)) begin
                    mem_respcyc = 1'b1;
                    mem_resp    = mem_word(mreq + 64'(fill_beat * 8));
                    drove       = 1'b1;
                    if (fill_beat == flush_beat) flush = 1'b1;
                    if (fill_beat == rst_beat) begin
                        #1 reset_n = 1'b0;
                        #1;
                        check_eq("rst_flags", 64'({reqack, respcyc, unsupported_req,
                                                  mem_reqcyc, mem_respack}), 64'd0);
                        check_eq("rst_resp", resp, 64'd0);
                        check_eq("rst_mem_req", mem_req, 64'd0);
                        mem_respcyc = 1'b0;
                        void'(sb_q.pop_front());
                        model_clear();
                        tick;
                        reset_n = 1'b1;
                        tick;
                        return;
                    end
                end
                tick;
                flush = 1'b0;
                if (drove) fill_beat++;
            end
        end
        if (!done) check_eq("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0] bases [4];
        logic [63:0] a;
        logic [9:0]  tg;

        tag_rd = {OP_READ, SPACE_MEMORY, 8'h03};
        tag_wr = {OP_WRITE, SPACE_MEMORY, 8'h23};
        reset_n = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
        flush = 1'b0; mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
        model_clear();
        repeat (3) tick;
        check_eq("reset_flags", 64'({reqack, respcyc, unsupported_req, mem_reqcyc, mem_respack}), 64'd0);
        check_eq("reset_resp", resp, 64'd0);
        check_eq("reset_mem_req", mem_req, 64'd0);
        reset_n = 1'b1;
        tick;

        do_read(64'h1008, tag_rd, 3, -1, 1'b0, -1, 1'b0);   // cold miss, beat 1 returned
        do_read(64'h1010, tag_rd, 0, -1, 1'b0, -1, 1'b0);   // hit, beat 2
        do_read(64'h2000, tag_rd, 1, -1, 1'b0, -1, 1'b0);   // conflict evicts 0x1000
        do_read(64'h1000, tag_rd, 0, -1, 1'b0, -1, 1'b0);   // refill
        do_read(64'h1000, tag_wr, 2, -1, 1'b0, -1, 1'b0);   // unsupported
        do_read(64'h1018, tag_rd, 0, -1, 1'b0, -1, 1'b0);   // line untouched -> hit
        do_read(64'h3040, tag_rd, 1, 3, 1'b0, -1, 1'b1);    // flush mid-fill
        do_read(64'h3040, tag_rd, 0, -1, 1'b0, -1, 1'b0);   // misses again
        do_read(64'h3048, tag_rd, 0, -1, 1'b1, -1, 1'b0);   // flush with req in IDLE
        do_read(64'h5000, tag_rd, 0, -1, 1'b0, 4, 1'b0);    // reset at beat 4
        do_read(64'h5000, tag_rd, 0, -1, 1'b0, -1, 1'b0);   // full refetch

        bases[0] = 64'h1000; bases[1] = 64'h2000; bases[2] = 64'h4040; bases[3] = 64'h7FC0;
        for (int i = 0; i < 24; i++) begin
            a  = bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 7) * 8);
            tg = ($urandom_range(0, 4) == 0) ? tag_wr : tag_rd;
            do_read(a, tg, $urandom_range(0, 3), -1, 1'b0, -1, 1'b1);
        end

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
